// File: rtl/l2_cache_control.sv
// l2_cache_control: sequencing FSM for the 2-way, write-back, write-allocate
// L2 cache datapath. It steers every select, load and write-enable of the
// datapath and consumes its hit/dirty status. Hit, clean-miss and dirty-miss
// (writeback then allocate) flows are handled with one outstanding request.
// Optional performance counters are enabled with the L2_PERF_CTR_EN macro.
module l2_cache_control
`ifdef L2_PERF_CTR_EN
  #(parameter int CTR_WIDTH = 32)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  input  logic       hit,
  input  logic       dirty,
  input  logic       pmem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  output logic       dataoutmux_sel,
  output logic       ld_lru,
  output logic       dirty_in,
  output logic       ld_dirty,
  output logic       data_in_sel,
  output logic       write_data,
  output logic       address_sel,
  output logic       way_sel,
  output logic [1:0] wenablemux_sel
`ifdef L2_PERF_CTR_EN
  ,
  output logic [CTR_WIDTH-1:0] hit_count,
  output logic [CTR_WIDTH-1:0] miss_count,
  output logic [CTR_WIDTH-1:0] wb_count
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // State register; reset returns to IDLE and abandons any memory transfer.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and datapath controls; everything is held low during reset so
  // no array write or memory request can escape an aborted operation.
  always_comb begin
    w_next         = r_state;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    dataoutmux_sel = 1'b0;
    ld_lru         = 1'b0;
    dirty_in       = 1'b0;
    ld_dirty       = 1'b0;
    data_in_sel    = 1'b0;
    write_data     = 1'b0;
    address_sel    = 1'b0;
    way_sel        = 1'b0;
    wenablemux_sel = 2'b00;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (mem_read || mem_write) w_next = COMPARE;
        end
        COMPARE: begin
          way_sel        = 1'b1;
          dataoutmux_sel = 1'b1;
          address_sel    = 1'b1;
          if (hit) begin
            mem_resp = 1'b1;
            ld_lru   = 1'b1;
            if (mem_write) begin
              wenablemux_sel = 2'b01;
              data_in_sel    = 1'b0;
              ld_dirty       = 1'b1;
              dirty_in       = 1'b1;
            end
            w_next = IDLE;
          end else if (dirty) begin
            w_next = WRITEBACK;
          end else begin
            w_next = ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          if (pmem_resp) begin
            ld_dirty = 1'b1;
            dirty_in = 1'b0;
            w_next   = ALLOCATE;
          end
        end
        ALLOCATE: begin
          address_sel = 1'b1;
          data_in_sel = 1'b1;
          pmem_read   = 1'b1;
          if (pmem_resp) begin
            wenablemux_sel = 2'b10;
            write_data     = 1'b1;
            ld_dirty       = 1'b1;
            dirty_in       = 1'b0;
            w_next         = COMPARE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

`ifdef L2_PERF_CTR_EN
  localparam logic [CTR_WIDTH-1:0] ONE = {{(CTR_WIDTH-1){1'b0}}, 1'b1};

  logic                 r_recompare;
  logic [CTR_WIDTH-1:0] r_hitCount;
  logic [CTR_WIDTH-1:0] r_missCount;
  logic [CTR_WIDTH-1:0] r_wbCount;

  // Remember that the coming COMPARE is the re-check after a line fill, so
  // its guaranteed hit is not counted as a genuine hit.
  always_ff @(posedge clk) begin
    if (rst)                                  r_recompare <= 1'b0;
    else if (r_state == ALLOCATE && pmem_resp) r_recompare <= 1'b1;
    else if (r_state == COMPARE)              r_recompare <= 1'b0;
  end

  // Saturating event counters for hits, misses and completed writebacks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hitCount  <= '0;
      r_missCount <= '0;
      r_wbCount   <= '0;
    end else begin
      if (r_state == COMPARE && hit && !r_recompare && r_hitCount != '1)
        r_hitCount <= r_hitCount + ONE;
      if (r_state == COMPARE && !hit && r_missCount != '1)
        r_missCount <= r_missCount + ONE;
      if (r_state == WRITEBACK && pmem_resp && r_wbCount != '1)
        r_wbCount <= r_wbCount + ONE;
    end
  end

  assign hit_count  = r_hitCount;
  assign miss_count = r_missCount;
  assign wb_count   = r_wbCount;
`endif

endmodule

// File: tb/tb_l2_cache_control.sv
// Testbench for l2_cache_control. A driver plays the upstream requester, a
// tiny datapath stub (line present / victim dirty) and physical memory with
// random latency. Each request pushes its expected outcome into a scoreboard
// queue; an independent monitor pops and compares at every mem_resp.
module tb_l2_cache_control;

  logic       clk;
  logic       rst;
  logic       mem_read;
  logic       mem_write;
  logic       mem_resp;
  logic       hit;
  logic       dirty;
  logic       pmem_resp;
  logic       pmem_read;
  logic       pmem_write;
  logic       dataoutmux_sel;
  logic       ld_lru;
  logic       dirty_in;
  logic       ld_dirty;
  logic       data_in_sel;
  logic       write_data;
  logic       address_sel;
  logic       way_sel;
  logic [1:0] wenablemux_sel;
`ifdef L2_PERF_CTR_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [31:0] wb_count;
`endif

  l2_cache_control dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_resp       (mem_resp),
    .hit            (hit),
    .dirty          (dirty),
    .pmem_resp      (pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .dataoutmux_sel (dataoutmux_sel),
    .ld_lru         (ld_lru),
    .dirty_in       (dirty_in),
    .ld_dirty       (ld_dirty),
    .data_in_sel    (data_in_sel),
    .write_data     (write_data),
    .address_sel    (address_sel),
    .way_sel        (way_sel),
    .wenablemux_sel (wenablemux_sel)
`ifdef L2_PERF_CTR_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count),
    .wb_count       (wb_count)
`endif
  );

  typedef struct {
    int latency;
    int wbCycles;
    int alCycles;
    int wrData;
    int dirtyClears;
    int isWrite;
  } exp_t;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nPass   = 0;
  bit   present;
  bit   dirtyBit;
  int   modelHits   = 0;
  int   modelMisses = 0;
  int   modelWbs    = 0;

  logic [12:0] outVec;
  assign outVec = {mem_resp, pmem_read, pmem_write, dataoutmux_sel, ld_lru,
                   dirty_in, ld_dirty, data_in_sel, write_data, address_sel,
                   way_sel, wenablemux_sel};

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One request. kind: 0 hit, 1 clean miss, 2 dirty miss.
  // op: 0 read, 1 write, 2 read+write (behaves as write).
  task automatic applyStimulus(input int kind, input int op, input int wbLat,
                               input int alLat, output bit timedOut);
    exp_t e;
    int   memCnt;
    int   budget;
    bit   done;
    bit   first;
    present  = (kind == 0);
    dirtyBit = (kind == 2);
    e.isWrite     = (op != 0) ? 1 : 0;
    e.wbCycles    = (kind == 2) ? wbLat : 0;
    e.alCycles    = (kind != 0) ? alLat : 0;
    e.latency     = 2 + e.wbCycles + ((kind != 0) ? alLat + 1 : 0);
    e.wrData      = (kind != 0) ? 1 : 0;
    e.dirtyClears = ((kind == 2) ? 1 : 0) + ((kind != 0) ? 1 : 0);
    sbQ.push_back(e);
    if (kind == 0) modelHits++;
    else           modelMisses++;
    if (kind == 2) modelWbs++;
    memCnt   = 0;
    budget   = 0;
    done     = 0;
    first    = 1;
    timedOut = 0;
    while (!done) begin
      @(posedge clk); #1;
      hit   = present;
      dirty = dirtyBit;
      if (first) begin
        mem_read  = (op == 0 || op == 2);
        mem_write = (op != 0);
        first     = 0;
      end
      #1;
      if (pmem_read || pmem_write) begin
        memCnt++;
        pmem_resp = (memCnt >= (pmem_write ? wbLat : alLat));
      end else begin
        memCnt    = 0;
        pmem_resp = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (write_data) present = 1;
      if (ld_dirty) dirtyBit = dirty_in;
      if (pmem_resp) memCnt = 0;
      budget++;
      if (mem_resp) begin
        done = 1;
      end else if (budget > 60) begin
        checkOutput("resp_timeout", 0, 1);
        timedOut = 1;
        done     = 1;
      end
    end
    @(posedge clk); #1;
    mem_read  = 0;
    mem_write = 0;
    pmem_resp = 0;
  endtask

  // Monitor: tracks the active request, accumulates per-request activity and
  // compares against the scoreboard entry when mem_resp appears.
  initial begin : monitor
    int   cyc;
    bit   active;
    bit   prevResp;
    int   nW, nR, nWd, nClr, addrErr, overlap;
    exp_t e;
    active   = 0;
    prevResp = 0;
    cyc = 0; nW = 0; nR = 0; nWd = 0; nClr = 0; addrErr = 0; overlap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active   = 0;
        prevResp = 0;
      end else begin
        if (prevResp) checkOutput("resp_one_cycle", int'(mem_resp), 0);
        prevResp = mem_resp;
        if (!active && (mem_read || mem_write)) begin
          active = 1;
          cyc = 0; nW = 0; nR = 0; nWd = 0; nClr = 0; addrErr = 0; overlap = 0;
        end
        if (active) begin
          cyc++;
          if (pmem_write) begin nW++; if (address_sel) addrErr++; end
          if (pmem_read) begin nR++; if (!address_sel) addrErr++; end
          if (pmem_read && pmem_write) overlap++;
          if (write_data) nWd++;
          if (ld_dirty && !dirty_in) nClr++;
          if (mem_resp) begin
            if (sbQ.size() == 0) begin
              checkOutput("resp_unexpected", 1, 0);
            end else begin
              e = sbQ.pop_front();
              checkOutput("latency", cyc, e.latency);
              checkOutput("pmem_write_cycles", nW, e.wbCycles);
              checkOutput("pmem_read_cycles", nR, e.alCycles);
              checkOutput("line_fills", nWd, e.wrData);
              checkOutput("dirty_clears", nClr, e.dirtyClears);
              checkOutput("pmem_address_sel", addrErr, 0);
              checkOutput("pmem_overlap", overlap, 0);
              checkOutput("resp_ld_lru", int'(ld_lru), 1);
              checkOutput("resp_way_sel", int'(way_sel), 1);
              checkOutput("resp_dataoutmux", int'(dataoutmux_sel), 1);
              checkOutput("resp_wenable", int'(wenablemux_sel), e.isWrite);
              checkOutput("resp_ld_dirty", int'(ld_dirty), e.isWrite);
              checkOutput("resp_dirty_in", int'(dirty_in), e.isWrite);
              checkOutput("resp_data_in_sel", int'(data_in_sel), 0);
            end
            active = 0;
          end
        end else begin
          checkOutput("idle_outputs", int'(outVec), 0);
        end
      end
    end
  end

  // Main sequence: reset, directed flows, random flows, reset abort.
  initial begin : driver
    bit to;
    bit anyTo;
    anyTo     = 0;
    rst       = 1;
    mem_read  = 0;
    mem_write = 0;
    hit       = 0;
    dirty     = 0;
    pmem_resp = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", int'(outVec), 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checkOutput("post_reset_outputs", int'(outVec), 0);

    applyStimulus(0, 0, 1, 1, to); anyTo |= to;
    applyStimulus(0, 1, 1, 1, to); anyTo |= to;
    applyStimulus(1, 0, 1, 5, to); anyTo |= to;
    applyStimulus(2, 1, 3, 4, to); anyTo |= to;
    applyStimulus(0, 2, 1, 1, to); anyTo |= to;
    applyStimulus(2, 0, 1, 1, to); anyTo |= to;

    for (int i = 0; i < 30 && !anyTo; i++) begin
      applyStimulus(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), to);
      anyTo |= to;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        pmem_resp = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      pmem_resp = 0;
    end

    if (!anyTo) begin
      repeat (2) @(posedge clk);
      checkOutput("scoreboard_empty", sbQ.size(), 0);
`ifdef L2_PERF_CTR_EN
      checkOutput("hit_count", int'(hit_count), modelHits);
      checkOutput("miss_count", int'(miss_count), modelMisses);
      checkOutput("wb_count", int'(wb_count), modelWbs);
`endif

      // Reset during the third ALLOCATE cycle of a clean read miss.
      hit = 0; dirty = 0; pmem_resp = 0;
      @(posedge clk); #1;
      mem_read = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("alloc_pmem_read", int'(pmem_read), 1);
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk);
      checkOutput("rst_cycle_write_data", int'(write_data), 0);
      @(posedge clk); #1;
      rst = 0;
      mem_read = 0;
      @(negedge clk);
      checkOutput("abort_pmem_read", int'(pmem_read), 0);
      checkOutput("abort_write_data", int'(write_data), 0);
`ifdef L2_PERF_CTR_EN
      checkOutput("rst_hit_count", int'(hit_count), 0);
`endif
      applyStimulus(0, 0, 1, 1, to);
      repeat (2) @(posedge clk);
      checkOutput("final_scoreboard_empty", sbQ.size(), 0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
